// File: rtl/pio_bidir_irq_if.sv
// Avalon-MM slave bus bundle for pio_bidir_irq: register select, write strobe and data,
// registered read data and level interrupt.
interface pio_bidir_irq_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/pio_bidir_irq.sv
// Parametrised bidirectional PIO: synchronised inputs, atomic set/clear of outputs,
// edge capture with per-bit masking and a registered level interrupt.
module pio_bidir_irq #(
   parameter int unsigned      WIDTH     = 4,
   parameter int unsigned      EDGE_TYPE = 0,
   parameter logic [WIDTH-1:0] DIR_RESET = '0,
   parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   pio_bidir_irq_if.slave  bus,
   inout  wire [WIDTH-1:0] bidir_port
);

   typedef enum logic [2:0] {
      A_DATA    = 3'd0,
      A_DIR     = 3'd1,
      A_IRQMASK = 3'd2,
      A_EDGECAP = 3'd3,
      A_OUTSET  = 3'd4,
      A_OUTCLR  = 3'd5
   } addr_e;

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_cap;
   logic             r_irq;
   logic [31:0]      r_rd;

   logic             w_wr;
   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_out_nxt;
   logic [31:0]      w_rdmux;
   logic             w_unused_wd;

   assign w_wr        = bus.chipselect & ~bus.write_n;
   assign w_wd        = bus.writedata[WIDTH-1:0];
   assign w_unused_wd = ^bus.writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign bidir_port[i] = r_dir[i] ? r_out[i] : 1'bz;
   end

   assign w_rise = r_s2 & ~r_prev;
   assign w_fall = ~r_s2 & r_prev;

   always_comb begin
      case (EDGE_TYPE)
         0:       w_edge = w_rise;
         1:       w_edge = w_fall;
         default: w_edge = w_rise | w_fall;
      endcase
   end

   assign w_clr = (w_wr && bus.address == A_EDGECAP) ? w_wd : '0;

   always_comb begin
      w_out_nxt = r_out;
      if (w_wr) begin
         case (bus.address)
            A_DATA:   w_out_nxt = w_wd;
            A_OUTSET: w_out_nxt = r_out | w_wd;
            A_OUTCLR: w_out_nxt = r_out & ~w_wd;
            default:  w_out_nxt = r_out;
         endcase
      end
   end

   // Read mux is evaluated every cycle; the interconnect relies on fixed one-cycle latency.
   always_comb begin
      w_rdmux = '0;
      case (bus.address)
         A_DATA:    w_rdmux[WIDTH-1:0] = r_s2;
         A_DIR:     w_rdmux[WIDTH-1:0] = r_dir;
         A_IRQMASK: w_rdmux[WIDTH-1:0] = r_mask;
         A_EDGECAP: w_rdmux[WIDTH-1:0] = r_cap;
         default:   w_rdmux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_prev <= '0;
         r_out  <= OUT_RESET;
         r_dir  <= DIR_RESET;
         r_mask <= '0;
         r_cap  <= '0;
         r_irq  <= 1'b0;
         r_rd   <= '0;
      end else begin
         r_s1   <= bidir_port;
         r_s2   <= r_s1;
         r_prev <= r_s2;
         r_out  <= w_out_nxt;
         if (w_wr && bus.address == A_DIR)     r_dir  <= w_wd;
         if (w_wr && bus.address == A_IRQMASK) r_mask <= w_wd;
         // A fresh edge wins over a same-cycle clear of that bit.
         r_cap  <= (r_cap & ~w_clr) | w_edge;
         r_irq  <= |(r_cap & r_mask);
         r_rd   <= w_rdmux;
      end
   end

   assign bus.readdata = r_rd;
   assign bus.irq      = r_irq;

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Bench for pio_bidir_irq: a 4-bit rising-edge instance and a 32-bit any-edge instance,
// directed steps plus a randomised run against a pin-timeline reference model.
module tb_pio_bidir_irq;
   localparam int NRND = 300;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   pio_bidir_irq_if ifa ();
   pio_bidir_irq_if ifb ();

   wire  [3:0]  pa;
   wire  [31:0] pb;
   logic [3:0]  a_oe, a_drv;
   logic [31:0] b_oe, b_drv;

   for (genvar i = 0; i < 4; i++) begin : g_pa
      assign pa[i] = a_oe[i] ? a_drv[i] : 1'bz;
   end
   for (genvar i = 0; i < 32; i++) begin : g_pb
      assign pb[i] = b_oe[i] ? b_drv[i] : 1'bz;
   end

   pio_bidir_irq #(
      .WIDTH(4), .EDGE_TYPE(0), .DIR_RESET(4'b0011), .OUT_RESET(4'b0001)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .bus(ifa), .bidir_port(pa)
   );

   pio_bidir_irq #(
      .WIDTH(32), .EDGE_TYPE(2), .DIR_RESET(32'h0), .OUT_RESET(32'h0)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .bus(ifb), .bidir_port(pb)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wr_a(input logic [2:0] addr, input logic [31:0] data);
      ifa.address = addr; ifa.writedata = data; ifa.chipselect = 1'b1; ifa.write_n = 1'b0;
      tick(1);
      ifa.chipselect = 1'b0; ifa.write_n = 1'b1;
   endtask

   task automatic rd_a(input logic [2:0] addr, output logic [31:0] data);
      ifa.address = addr; ifa.chipselect = 1'b1;
      tick(1);
      data = ifa.readdata;
      ifa.chipselect = 1'b0;
   endtask

   task automatic wr_b(input logic [2:0] addr, input logic [31:0] data);
      ifb.address = addr; ifb.writedata = data; ifb.chipselect = 1'b1; ifb.write_n = 1'b0;
      tick(1);
      ifb.chipselect = 1'b0; ifb.write_n = 1'b1;
   endtask

   task automatic rd_b(input logic [2:0] addr, output logic [31:0] data);
      ifb.address = addr; ifb.chipselect = 1'b1;
      tick(1);
      data = ifb.readdata;
      ifb.chipselect = 1'b0;
   endtask

   // Reference state for the random run; pinh[k+3] is the pin vector during cycle k.
   logic [3:0]  m_out, m_dir, m_mask, m_cap;
   logic        m_irq;
   logic [31:0] m_rd;
   logic [3:0]  pinh [0:NRND+3];

   initial begin
      logic [31:0] v;
      logic [31:0] rd_n;
      logic [31:0] wd;
      logic [3:0]  p, wd4, rise;
      logic [2:0]  addr;
      logic        cs, wn, wr;

      reset_n = 1'b0;
      a_oe = 4'hC; a_drv = 4'h0;
      b_oe = '1;   b_drv = '0;
      ifa.address = '0; ifa.chipselect = 1'b0; ifa.write_n = 1'b1; ifa.writedata = '0;
      ifb.address = '0; ifb.chipselect = 1'b0; ifb.write_n = 1'b1; ifb.writedata = '0;

      // Reset values
      @(negedge clk); @(negedge clk);
      chk("rst_pins_a", {30'b0, pa[1:0]}, 32'h1);
      chk("rst_rd_a", ifa.readdata, 32'h0);
      chk("rst_irq_a", {31'b0, ifa.irq}, 32'h0);
      chk("rst_rd_b", ifb.readdata, 32'h0);
      chk("rst_irq_b", {31'b0, ifb.irq}, 32'h0);
      reset_n = 1'b1;
      tick(4);
      rd_a(3'd1, v); chk("rst_dir_a", v, 32'h3);
      rd_a(3'd0, v); chk("rst_din_a", v, 32'h1);
      rd_a(3'd2, v); chk("rst_mask_a", v, 32'h0);
      // Pin 0 rises from the all-zero synchroniser state, so it is captured.
      rd_a(3'd3, v); chk("rst_cap_a", v, 32'h1);
      chk("rst_irq_a2", {31'b0, ifa.irq}, 32'h0);
      wr_a(3'd3, 32'hF);
      rd_a(3'd3, v); chk("cap_clr_a", v, 32'h0);

      // Output drive and atomic set/clear
      wr_a(3'd1, 32'hF);
      a_oe = 4'h0;
      chk("dir_pins", {28'b0, pa}, 32'h1);
      wr_a(3'd0, 32'hA); chk("data_pins", {28'b0, pa}, 32'hA);
      wr_a(3'd4, 32'h5); chk("outset_pins", {28'b0, pa}, 32'hF);
      wr_a(3'd5, 32'h3); chk("outclr_pins", {28'b0, pa}, 32'hC);
      ifa.address = 3'd0;
      tick(2); chk("din_lag", ifa.readdata, 32'hF);
      tick(1); chk("din_new", ifa.readdata, 32'hC);

      // Masked edge capture and interrupt latency
      a_drv = 4'hC; a_oe = 4'hF;
      wr_a(3'd1, 32'h0);
      wr_a(3'd2, 32'h2);
      tick(4);
      wr_a(3'd3, 32'hF);
      tick(2);
      chk("irq_idle", {31'b0, ifa.irq}, 32'h0);
      a_drv = 4'hD;
      tick(5);
      chk("irq_masked_bit0", {31'b0, ifa.irq}, 32'h0);
      rd_a(3'd3, v); chk("cap_bit0", v, 32'h1);
      wr_a(3'd3, 32'hF);
      tick(2);
      a_drv = 4'hF;
      tick(3); chk("irq_t3", {31'b0, ifa.irq}, 32'h0);
      tick(1); chk("irq_t4", {31'b0, ifa.irq}, 32'h1);
      rd_a(3'd3, v); chk("cap_bit1", v, 32'h2);

      // Clear colliding with a new edge on the same bit
      a_drv = 4'hD;
      tick(4);
      a_drv = 4'hF;
      tick(2);
      wr_a(3'd3, 32'h2);
      chk("collide_irq", {31'b0, ifa.irq}, 32'h1);
      rd_a(3'd3, v); chk("collide_cap", v, 32'h2);
      chk("collide_irq2", {31'b0, ifa.irq}, 32'h1);
      wr_a(3'd3, 32'h2);
      chk("clr_irq_lag", {31'b0, ifa.irq}, 32'h1);
      tick(1);
      chk("clr_irq_drop", {31'b0, ifa.irq}, 32'h0);

      // Random run: pins 1:0 outputs, pins 3:2 driven by the bench
      a_drv = 4'hC;
      tick(1);
      wr_a(3'd1, 32'h3);
      a_oe = 4'hC;
      wr_a(3'd0, 32'h2);
      wr_a(3'd2, 32'h6);
      tick(4);
      wr_a(3'd3, 32'hF);
      tick(1);
      wr_a(3'd3, 32'hF);
      ifa.address = 3'd0;
      tick(3);
      m_out = 4'h2; m_dir = 4'h3; m_mask = 4'h6; m_cap = 4'h0; m_irq = 1'b0;
      m_rd  = 32'hE;
      for (int k = 0; k < 3; k++) pinh[k] = 4'hE;

      for (int n = 0; n < NRND; n++) begin
         chk("rnd_rd", ifa.readdata, m_rd);
         chk("rnd_irq", {31'b0, ifa.irq}, {31'b0, m_irq});
         chk("rnd_pins", {30'b0, pa[1:0]}, {30'b0, m_out[1:0]});

         cs   = ($urandom_range(0, 3) != 0);
         wn   = 1'($urandom_range(0, 1));
         addr = 3'($urandom_range(0, 7));
         if (addr == 3'd1) addr = 3'd3;
         wd   = $urandom;
         if ($urandom_range(0, 2) == 0) a_drv[3:2] = 2'($urandom_range(0, 3));
         ifa.address = addr; ifa.chipselect = cs; ifa.write_n = wn; ifa.writedata = wd;

         // Pin level reaches readdata two cycles on; a rise is captured one cycle after that.
         p   = (m_out & m_dir) | (a_drv & ~m_dir);
         pinh[n+3] = p;
         wr  = cs & ~wn;
         wd4 = wd[3:0];
         case (addr)
            3'd0:    rd_n = {28'b0, pinh[n+1]};
            3'd1:    rd_n = {28'b0, m_dir};
            3'd2:    rd_n = {28'b0, m_mask};
            3'd3:    rd_n = {28'b0, m_cap};
            default: rd_n = 32'h0;
         endcase
         rise  = pinh[n+1] & ~pinh[n];
         m_irq = |(m_cap & m_mask);
         m_cap = (m_cap & ~((wr && addr == 3'd3) ? wd4 : 4'h0)) | rise;
         if (wr) begin
            case (addr)
               3'd0: m_out = wd4;
               3'd2: m_mask = wd4;
               3'd4: m_out = m_out | wd4;
               3'd5: m_out = m_out & ~wd4;
               default: ;
            endcase
         end
         m_rd = rd_n;
         tick(1);
      end
      chk("rnd_rd_end", ifa.readdata, m_rd);
      chk("rnd_irq_end", {31'b0, ifa.irq}, {31'b0, m_irq});
      ifa.chipselect = 1'b0; ifa.write_n = 1'b1;

      // 32-bit any-edge instance
      rd_b(3'd3, v); chk("b_cap0", v, 32'h0);
      b_drv[31] = 1'b1;
      tick(4);
      rd_b(3'd3, v); chk("b_rise", v, 32'h8000_0000);
      chk("b_irq_masked", {31'b0, ifb.irq}, 32'h0);
      wr_b(3'd3, 32'hFFFF_FFFF);
      rd_b(3'd3, v); chk("b_clr", v, 32'h0);
      b_drv[31] = 1'b0;
      tick(4);
      rd_b(3'd3, v); chk("b_fall", v, 32'h8000_0000);
      wr_b(3'd6, 32'hFFFF_FFFF);
      rd_b(3'd1, v); chk("b_dir_a6", v, 32'h0);
      rd_b(3'd2, v); chk("b_mask_a6", v, 32'h0);
      rd_b(3'd0, v); chk("b_din", v, 32'h0);
      rd_b(3'd6, v); chk("b_rd6", v, 32'h0);
      rd_b(3'd3, v); chk("b_cap_a6", v, 32'h8000_0000);
      wr_b(3'd2, 32'h8000_0000);
      chk("b_unmask_lag", {31'b0, ifb.irq}, 32'h0);
      tick(1);
      chk("b_unmask_irq", {31'b0, ifb.irq}, 32'h1);

      // Reset in the middle of a write with captures pending
      a_drv = 4'h0;
      wr_a(3'd2, 32'hF);
      wr_a(3'd0, 32'h0);
      tick(4);
      wr_a(3'd0, 32'h3);
      tick(5);
      chk("pre_rst_irq_a", {31'b0, ifa.irq}, 32'h1);
      ifa.address = 3'd0; ifa.writedata = 32'h0; ifa.chipselect = 1'b1; ifa.write_n = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_irq_a", {31'b0, ifa.irq}, 32'h0);
      chk("mid_rst_irq_b", {31'b0, ifb.irq}, 32'h0);
      chk("mid_rst_rd_a", ifa.readdata, 32'h0);
      chk("mid_rst_pins_a", {30'b0, pa[1:0]}, 32'h1);
      @(negedge clk);
      ifa.chipselect = 1'b0; ifa.write_n = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      tick(4);
      rd_a(3'd3, v); chk("post_rst_cap_a", v, 32'h1);
      rd_a(3'd2, v); chk("post_rst_mask_a", v, 32'h0);
      rd_a(3'd1, v); chk("post_rst_dir_a", v, 32'h3);
      chk("post_rst_irq_a", {31'b0, ifa.irq}, 32'h0);
      rd_b(3'd3, v); chk("post_rst_cap_b", v, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pio_bidir_irq.md
Name: pio_bidir_irq

Overview:
Parametrised Avalon-MM bidirectional parallel I/O port, WIDTH pins wide. It is the successor to the fixed 4-bit bidirectional PIO used for SD-card DAT lines. Adds:
- Input synchronisation
- Atomic set/clear of output bits
- Edge capture with per-bit interrupt masking and a level interrupt output

It sits on the system interconnect as a slave, alongside the other QSYS peripherals.

Parameters:
WIDTH, 4, number of pins (1..32)
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
DIR_RESET, 0, reset value of direction register (WIDTH bits; 1 = output)
OUT_RESET, 0, reset value of output data register (WIDTH bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits [WIDTH-1:0] used
readdata  out  32  registered read data, zero-extended above WIDTH
irq  out  1  level interrupt, active high
bidir_port  inout  WIDTH  external pins

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk. All registers are reset asynchronously and release synchronously to clk.
- Reset values: readdata 0, data_out OUT_RESET, data_dir DIR_RESET, irq_mask 0, edge_capture 0, sync/prev stages 0, irq 0.
- Write definition: a write is chipselect=1 and write_n=0 in a cycle.
- Pin drive: per bit, bidir_port[i] = data_dir[i] ? data_out[i] : Z. The input path always samples the pin, including pins driven as outputs.
- Synchroniser: 2-flop synchroniser, bidir_port -> s1 -> s2; data_in = s2. One further register, prev, holds the previous s2.
- Edge detect: rise = s2 & ~prev; fall = ~s2 & prev; edge selected per EDGE_TYPE. A pin change shows in data_in 2 cycles later and sets edge_capture 3 cycles later.
- Register map:
  - 0 DATA: read data_in; write data_out <= wd.
  - 1 DIR: read/write data_dir.
  - 2 IRQMASK: read/write irq_mask.
  - 3 EDGECAP: read edge_capture; write-1-to-clear bits.
  - 4 OUTSET: write data_out <= data_out | wd; reads 0.
  - 5 OUTCLR: write data_out <= data_out & ~wd; reads 0.
  - 6, 7: reads 0; writes ignored.
- Read timing: readdata <= zero-extended mux(address) every clk, regardless of chipselect. Read latency is 1 cycle; the interconnect must be configured for 1 wait-free read latency.
- Edge capture: edge_capture[i] <= (edge_capture[i] & ~clr[i]) | edge[i]. clr[i] is wd[i] only during a write to address 3. If a new edge and a clear hit the same bit in the same cycle, the bit stays set.
- Interrupt: irq registered; irq <= |(edge_capture & irq_mask), so irq is 1 cycle after edge_capture. Unmasking a pending capture asserts irq 1 cycle after the mask write is registered.
- Reset mid-operation: all state returns to reset values immediately. Pins follow DIR_RESET/OUT_RESET combinationally. Captured edges are lost.
- Bits of writedata at or above WIDTH are ignored. Readdata bits at or above WIDTH are always 0.

Test Plan:
- Reset with WIDTH=4, DIR_RESET=4'b0011, OUT_RESET=4'b0001 -> bidir_port = {Z,Z,0,1}; read addr 1 returns 0x3; read addr 0/2/3 return their reset values; irq=0.
- Write DIR=0xF, then DATA=0xA, OUTSET=0x5, OUTCLR=0x3 -> port 0xA, then 0xF, then 0xC; read addr 0 returns 0xC, lagging the pin change by 2 cycles plus 1 cycle read latency.
- EDGE_TYPE=0, DIR=0, IRQMASK=0x2; external bit1 0->1 at cycle T -> edge_capture[1]=1 at T+3, irq=1 at T+4; bit0 rising sets edge_capture[0] but irq is unaffected.
- Write EDGECAP=0x2 in the same cycle a new rising edge on bit1 reaches the edge stage -> edge_capture[1] stays 1 and irq stays 1. A later clear with no edge -> irq drops 1 cycle after capture clears.
- EDGE_TYPE=2, WIDTH=32: toggle bit31 high then low -> each transition captured (capture, clear, recapture). Read addr 3 returns 0x80000000. A write with wd=0xFFFFFFFF to addr 6 changes nothing.
- Assert reset_n low mid-transfer while edge_capture is nonzero and irq=1 -> irq=0, edge_capture=0, pins revert to reset drive asynchronously.
